// File: rtl/gate_vector_checker.sv
// Stimulus/check engine for two-operand bitwise gate blocks: sweeps every a/b
// combination, waits SETTLE extra cycles per vector, and tallies mismatches.
module gate_vector_checker #(
    parameter int WIDTH  = 1,
    parameter int SETTLE = 1,
    parameter int OP     = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   a_out,
    output logic [WIDTH-1:0]   b_out,
    input  logic [WIDTH-1:0]   dut_out,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_count,
    output logic               fail_valid,
    output logic [2*WIDTH-1:0] first_fail
);

    localparam int            IW         = 2 * WIDTH;
    localparam logic [IW-1:0] LAST_IDX   = '1;
    localparam logic [3:0]    SETTLE_CNT = 4'(SETTLE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [IW-1:0]   idx;
    logic [3:0]      hold;
    logic [WIDTH-1:0] expected;
    logic            mismatch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (hold == 4'd0 && idx == LAST_IDX) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        case (OP)
            1:       expected = a_out | b_out;
            2:       expected = a_out ^ b_out;
            default: expected = a_out & b_out;
        endcase
    end

    // Equality is tested positively so an X/Z on dut_out falls through as a mismatch.
    always_comb begin
        mismatch = 1'b1;
        if (dut_out == expected) begin
            mismatch = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= '0;
            hold       <= '0;
            a_out      <= '0;
            b_out      <= '0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx        <= '0;
                        a_out      <= '0;
                        b_out      <= '0;
                        hold       <= SETTLE_CNT;
                        pass       <= 1'b0;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        first_fail <= '0;
                    end
                end
                S_RUN: begin
                    if (hold != 4'd0) begin
                        hold <= hold - 4'd1;
                    end else begin
                        if (mismatch) begin
                            err_count <= err_count + 1'b1;
                            if (!fail_valid) begin
                                first_fail <= idx;
                                fail_valid <= 1'b1;
                            end
                        end
                        if (idx != LAST_IDX) begin
                            idx            <= idx + 1'b1;
                            {a_out, b_out} <= idx + 1'b1;
                            hold           <= SETTLE_CNT;
                        end else begin
                            a_out <= '0;
                            b_out <= '0;
                            // The final compare has not reached err_count yet, so fold it in here.
                            pass  <= (err_count == '0) && !mismatch;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_vector_checker.sv
// Directed bench for gate_vector_checker: four checker configurations, each
// facing a small behavioural gate model, driven from a table plus corner sequences.
module tb_gate_vector_checker;

    typedef struct {
        int inst;
        int mode;
        int busyCyc;
        int pass;
        int errCnt;
        int failValid;
        int firstFail;
    } vec_t;

    logic clk;
    logic rst;
    logic startV [4];
    int   modeV  [4];

    logic       busyV [4];
    logic       doneV [4];
    logic       passV [4];
    logic       fvV   [4];
    logic [7:0] errV  [4];
    logic [7:0] ffV   [4];
    logic [7:0] abV   [4];

    int vectorsApplied = 0;
    int miscompares    = 0;

    // Instance 0: WIDTH=1, SETTLE=1, AND checker
    logic       a0, b0, d0;
    logic [2:0] err0;
    logic [1:0] ff0;
    gate_vector_checker #(.WIDTH(1), .SETTLE(1), .OP(0)) u0 (
        .clk(clk), .rst(rst), .start(startV[0]), .a_out(a0), .b_out(b0),
        .dut_out(d0), .busy(busyV[0]), .done(doneV[0]), .pass(passV[0]),
        .err_count(err0), .fail_valid(fvV[0]), .first_fail(ff0));

    always_comb begin
        case (modeV[0])
            1:       d0 = 1'b0;
            2:       d0 = a0 | b0;
            default: d0 = a0 & b0;
        endcase
    end

    // Instance 1: WIDTH=2, SETTLE=0, XOR checker
    logic [1:0] a1, b1, d1;
    logic [4:0] err1;
    logic [3:0] ff1;
    gate_vector_checker #(.WIDTH(2), .SETTLE(0), .OP(2)) u1 (
        .clk(clk), .rst(rst), .start(startV[1]), .a_out(a1), .b_out(b1),
        .dut_out(d1), .busy(busyV[1]), .done(doneV[1]), .pass(passV[1]),
        .err_count(err1), .fail_valid(fvV[1]), .first_fail(ff1));

    assign d1 = (modeV[1] == 1) ? ~(a1 ^ b1) : (a1 ^ b1);

    // Instances 2 and 3: AND gate seen through two pipeline registers
    logic       a2, b2, a3, b3;
    logic       p2a, p2b, p3a, p3b;
    logic [2:0] err2, err3;
    logic [1:0] ff2, ff3;
    gate_vector_checker #(.WIDTH(1), .SETTLE(2), .OP(0)) u2 (
        .clk(clk), .rst(rst), .start(startV[2]), .a_out(a2), .b_out(b2),
        .dut_out(p2b), .busy(busyV[2]), .done(doneV[2]), .pass(passV[2]),
        .err_count(err2), .fail_valid(fvV[2]), .first_fail(ff2));
    gate_vector_checker #(.WIDTH(1), .SETTLE(0), .OP(0)) u3 (
        .clk(clk), .rst(rst), .start(startV[3]), .a_out(a3), .b_out(b3),
        .dut_out(p3b), .busy(busyV[3]), .done(doneV[3]), .pass(passV[3]),
        .err_count(err3), .fail_valid(fvV[3]), .first_fail(ff3));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p2a <= 1'b0; p2b <= 1'b0; p3a <= 1'b0; p3b <= 1'b0;
        end else begin
            p2a <= a2 & b2; p2b <= p2a;
            p3a <= a3 & b3; p3b <= p3a;
        end
    end

    assign errV[0] = 8'(err0); assign errV[1] = 8'(err1);
    assign errV[2] = 8'(err2); assign errV[3] = 8'(err3);
    assign ffV[0]  = 8'(ff0);  assign ffV[1]  = 8'(ff1);
    assign ffV[2]  = 8'(ff2);  assign ffV[3]  = 8'(ff3);
    assign abV[0]  = 8'({a0, b0}); assign abV[1] = 8'({a1, b1});
    assign abV[2]  = 8'({a2, b2}); assign abV[3] = 8'({a3, b3});

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectorsApplied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Pulses start, counts busy cycles until done; optionally re-pulses start mid-run.
    task automatic applyStimulus(input int inst, input int mode, input int repulseAt,
                                 output int busyCyc, output int seenDone);
        busyCyc  = 0;
        seenDone = 0;
        modeV[inst] = mode;
        @(negedge clk);
        startV[inst] = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (busyV[inst]) begin
                busyCyc++;
                startV[inst] = (busyCyc == repulseAt);
            end else begin
                startV[inst] = 1'b0;
                if (doneV[inst]) begin
                    seenDone = 1;
                    break;
                end
            end
        end
        startV[inst] = 1'b0;
    endtask

    vec_t vecs [7];
    int   busyCyc;
    int   seenDone;

    initial begin
        vecs[0] = '{inst: 0, mode: 0, busyCyc: 8,  pass: 1, errCnt: 0,  failValid: 0, firstFail: 0};
        vecs[1] = '{inst: 0, mode: 1, busyCyc: 8,  pass: 0, errCnt: 1,  failValid: 1, firstFail: 3};
        vecs[2] = '{inst: 0, mode: 2, busyCyc: 8,  pass: 0, errCnt: 2,  failValid: 1, firstFail: 1};
        vecs[3] = '{inst: 1, mode: 0, busyCyc: 16, pass: 1, errCnt: 0,  failValid: 0, firstFail: 0};
        vecs[4] = '{inst: 1, mode: 1, busyCyc: 16, pass: 0, errCnt: 16, failValid: 1, firstFail: 0};
        vecs[5] = '{inst: 2, mode: 0, busyCyc: 12, pass: 1, errCnt: 0,  failValid: 0, firstFail: 0};
        vecs[6] = '{inst: 3, mode: 0, busyCyc: 4,  pass: 0, errCnt: 1,  failValid: 1, firstFail: 3};

        for (int i = 0; i < 4; i++) begin
            startV[i] = 1'b0;
            modeV[i]  = 0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", busyV[0], 0);
        checkOutput("reset_done", doneV[0], 0);
        checkOutput("reset_pass", passV[0], 0);
        checkOutput("reset_err",  errV[0],  0);
        checkOutput("reset_fv",   fvV[0],   0);
        checkOutput("reset_ab",   abV[0],   0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].inst, vecs[i].mode, -1, busyCyc, seenDone);
            checkOutput($sformatf("v%0d_done_seen", i), seenDone, 1);
            checkOutput($sformatf("v%0d_busy_cycles", i), busyCyc, vecs[i].busyCyc);
            checkOutput($sformatf("v%0d_pass", i), passV[vecs[i].inst], vecs[i].pass);
            checkOutput($sformatf("v%0d_err_count", i), errV[vecs[i].inst], vecs[i].errCnt);
            checkOutput($sformatf("v%0d_fail_valid", i), fvV[vecs[i].inst], vecs[i].failValid);
            checkOutput($sformatf("v%0d_first_fail", i), ffV[vecs[i].inst], vecs[i].firstFail);
            checkOutput($sformatf("v%0d_ab_idle", i), abV[vecs[i].inst], 0);
            @(negedge clk);
            checkOutput($sformatf("v%0d_done_pulse", i), doneV[vecs[i].inst], 0);
            checkOutput($sformatf("v%0d_pass_held", i), passV[vecs[i].inst], vecs[i].pass);
            repeat (2) @(negedge clk);
        end

        // Vector order and hold: 00,01,10,11 each for SETTLE+1 = 2 cycles
        modeV[0] = 0;
        startV[0] = 1'b1;
        @(negedge clk);
        startV[0] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            checkOutput($sformatf("seq_busy_c%0d", c), busyV[0], 1);
            checkOutput($sformatf("seq_ab_c%0d", c), abV[0], c / 2);
            @(negedge clk);
        end
        checkOutput("seq_done", doneV[0], 1);
        checkOutput("seq_busy_low", busyV[0], 0);
        repeat (3) @(negedge clk);

        // A start pulse during busy cycle 3 must not restart or extend the run
        applyStimulus(0, 0, 3, busyCyc, seenDone);
        checkOutput("repulse_done_seen", seenDone, 1);
        checkOutput("repulse_busy_cycles", busyCyc, 8);
        checkOutput("repulse_pass", passV[0], 1);
        checkOutput("repulse_err", errV[0], 0);
        repeat (3) @(negedge clk);

        // Reset mid-run after the OR model has produced a mismatch
        modeV[0] = 2;
        startV[0] = 1'b1;
        @(negedge clk);
        startV[0] = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("midrun_err_before_rst", errV[0], 1);
        rst = 1'b1;
        #1;
        checkOutput("midrun_rst_busy", busyV[0], 0);
        checkOutput("midrun_rst_err",  errV[0],  0);
        checkOutput("midrun_rst_fv",   fvV[0],   0);
        checkOutput("midrun_rst_ff",   ffV[0],   0);
        checkOutput("midrun_rst_ab",   abV[0],   0);
        checkOutput("midrun_rst_pass", passV[0], 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        applyStimulus(0, 0, -1, busyCyc, seenDone);
        checkOutput("after_rst_done_seen", seenDone, 1);
        checkOutput("after_rst_busy_cycles", busyCyc, 8);
        checkOutput("after_rst_pass", passV[0], 1);
        checkOutput("after_rst_err", errV[0], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
